// File: rtl/serial_negate_sequencer_if.sv
// Handshake bundle for serial_negate_sequencer.
//   in_valid/in_ready/in_op/in_data    : operand and opcode from the producer
//   out_valid/out_ready/out_data/out_ovf : result to the consumer
//   busy                                 : sequencer is shifting or holding a result
// The master modport is the producer/consumer side. The slave modport is the sequencer side.
interface serial_negate_sequencer_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;
  logic             busy;

  modport master (
    output in_valid,
    output in_op,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_ovf,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_op,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_ovf,
    output busy
  );
endinterface

// File: rtl/serial_negate_sequencer.sv
// Bit-serial complement unit.
// An operand and an opcode are accepted in IDLE:
//   00 pass, 01 ones-complement, 10 twos-complement, 11 absolute value.
// The operand is loaded into a right-shift register. It is then shifted LSB-first through a
// one-bit adder for WIDTH cycles. The result is held in DONE until the consumer takes it.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of serial_negate_sequencer_if. It carries the input handshake, the
//           output handshake, out_ovf and busy.
module serial_negate_sequencer #(
  parameter int unsigned  WIDTH = 4,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  serial_negate_sequencer_if.slave     bus
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [WIDTH-1:0] MinNeg   = {1'b1, {(WIDTH - 1){1'b0}}};
  localparam logic [CNT_W-1:0] LastCount = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               carry_q, carry_d;
  logic               inv_q, inv_d;
  logic               ovf_q, ovf_d;

  logic               accept;
  logic               last_shift;
  logic               in_msb;
  logic               bit_x;
  logic               bit_s;

  assign accept     = (state_q == StIdle) && bus.in_valid;
  assign last_shift = (count_q == LastCount);
  assign in_msb     = bus.in_data[WIDTH-1];
  // Serial adder cell. The operand bit is optionally inverted, then the carry is added.
  // Only +0 or +1 is ever added, so the carry can only propagate; it is never generated.
  assign bit_x      = shift_q[0] ^ inv_q;
  assign bit_s      = bit_x ^ carry_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.in_valid)  state_d = StShift;
      StShift: if (last_shift)    state_d = StDone;
      StDone:  if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic. The result and the flag are forced to zero outside DONE.
  always_comb begin
    bus.in_ready  = (state_q == StIdle);
    bus.out_valid = (state_q == StDone);
    bus.out_data  = (state_q == StDone) ? shift_q : '0;
    bus.out_ovf   = (state_q == StDone) & ovf_q;
    bus.busy      = (state_q == StShift) || (state_q == StDone);
  end

  // Datapath next-state
  always_comb begin
    shift_d = shift_q;
    count_d = count_q;
    carry_d = carry_q;
    inv_d   = inv_q;
    ovf_d   = ovf_q;
    if (accept) begin
      shift_d = bus.in_data;
      count_d = '0;
      // Abs behaves as twos-complement for negative operands and as pass otherwise.
      inv_d   = (bus.in_op == 2'b01) || (bus.in_op == 2'b10) ||
                ((bus.in_op == 2'b11) && in_msb);
      carry_d = (bus.in_op == 2'b10) || ((bus.in_op == 2'b11) && in_msb);
      // Negating the most-negative value gives that same value back.
      ovf_d   = bus.in_op[1] && (bus.in_data == MinNeg);
    end else if (state_q == StShift) begin
      shift_d = {bit_s, shift_q[WIDTH-1:1]};
      carry_d = bit_x & carry_q;
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      inv_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      count_q <= count_d;
      carry_q <= carry_d;
      inv_q   <= inv_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_serial_negate_sequencer.sv
// Directed and random-stream bench for serial_negate_sequencer (WIDTH=4).
module tb_serial_negate_sequencer;

  localparam int unsigned W = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  serial_negate_sequencer_if #(.WIDTH(W)) bus ();

  serial_negate_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one operation and consumes its result. Latency is counted in edges after the
  // accept edge; it returns 99 if no result appears.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] data, output int lat,
                       output logic [W-1:0] res, output logic ovf);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    bus.in_op    = op;
    bus.in_data  = data;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    if (!bus.out_valid) lat = 99;
    res = bus.out_data;
    ovf = bus.out_ovf;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'b00;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    checks++;
    if (bus.out_data !== 4'b0000) begin
      errors++; $display("FAIL reset_out_data: got %b expected 0000", bus.out_data);
    end
    checks++;
    if (bus.out_ovf !== 1'b0) begin
      errors++; $display("FAIL reset_out_ovf: got %b expected 0", bus.out_ovf);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Twos-complement vectors: a plain value, the most-negative value and zero.
  task automatic test_twos();
    logic [1:0]   ops [3];
    logic [W-1:0] din [3];
    logic [W-1:0] exp_d [3];
    logic         exp_o [3];
    int           lat;
    logic [W-1:0] res;
    logic         ovf;
    ops = '{2'b10, 2'b10, 2'b10};
    din = '{4'b0011, 4'b1000, 4'b0000};
    exp_d = '{4'b1101, 4'b1000, 4'b0000};
    exp_o = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], din[i], lat, res, ovf);
      checks++;
      if (lat !== 4) begin
        errors++; $display("FAIL twos_latency[%0d]: got %0d expected 4", i, lat);
      end
      checks++;
      if (res !== exp_d[i]) begin
        errors++; $display("FAIL twos_data[%0d]: got %b expected %b", i, res, exp_d[i]);
      end
      checks++;
      if (ovf !== exp_o[i]) begin
        errors++; $display("FAIL twos_ovf[%0d]: got %b expected %b", i, ovf, exp_o[i]);
      end
    end
  endtask

  // Pass, ones-complement and both branches of abs, including abs of the most-negative value.
  task automatic test_ops();
    logic [1:0]   ops [5];
    logic [W-1:0] din [5];
    logic [W-1:0] exp_d [5];
    logic         exp_o [5];
    int           lat;
    logic [W-1:0] res;
    logic         ovf;
    ops = '{2'b01, 2'b00, 2'b11, 2'b11, 2'b11};
    din = '{4'b0101, 4'b0110, 4'b1110, 4'b0111, 4'b1000};
    exp_d = '{4'b1010, 4'b0110, 4'b0010, 4'b0111, 4'b1000};
    exp_o = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], din[i], lat, res, ovf);
      checks++;
      if (res !== exp_d[i] || ovf !== exp_o[i]) begin
        errors++;
        $display("FAIL ops[%0d]: got %b/%b expected %b/%b", i, res, ovf, exp_d[i], exp_o[i]);
      end
    end
  endtask

  // Consumer stalls in DONE while the producer pulses in_valid.
  task automatic test_stall();
    int guard;
    bus.in_op = 2'b01; bus.in_data = 4'b0011; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    guard = 0;
    while (!bus.out_valid && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.in_op    = 2'b00;
      bus.in_data  = 4'(i);
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 4'b1100 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v=%b d=%b r=%b expected v=1 d=1100 r=0", i,
                 bus.out_valid, bus.out_data, bus.in_ready);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: got r=%b v=%b b=%b expected r=1 v=0 b=0",
               bus.in_ready, bus.out_valid, bus.busy);
    end
    bus.in_op = 2'b00; bus.in_data = 4'b1001; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_next_accept: got busy=%b in_ready=%b expected busy=1 in_ready=0",
               bus.busy, bus.in_ready);
    end
    guard = 0;
    while (!bus.out_valid && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    checks++;
    if (bus.out_data !== 4'b1001) begin
      errors++; $display("FAIL stall_next_data: got %b expected 1001", bus.out_data);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  // Reset is applied in the middle of SHIFT. No partial result may follow.
  task automatic test_reset_mid();
    int           lat;
    logic [W-1:0] res;
    logic         ovf;
    bus.in_op = 2'b10; bus.in_data = 4'b0011; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 4'b0000 ||
        bus.out_ovf !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got r=%b v=%b d=%b o=%b b=%b expected r=1 v=0 d=0000 o=0 b=0",
               bus.in_ready, bus.out_valid, bus.out_data, bus.out_ovf, bus.busy);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL midreset_no_result: got %b expected 0", bus.out_valid);
      end
    end
    bus.out_ready = 1'b0;
    issue(2'b10, 4'b0001, lat, res, ovf);
    checks++;
    if (lat !== 4 || res !== 4'b1111 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL midreset_fresh: got lat=%0d d=%b o=%b expected lat=4 d=1111 o=0",
               lat, res, ovf);
    end
  endtask

  // Reference model for the stream test.
  function automatic logic [W:0] model(input logic [1:0] op, input logic [W-1:0] d);
    logic [W-1:0] r;
    logic         o;
    case (op)
      2'b00:   r = d;
      2'b01:   r = ~d;
      2'b10:   r = 4'd0 - d;
      default: r = d[W-1] ? 4'd0 - d : d;
    endcase
    o = op[1] && (d == 4'b1000);
    return {o, r};
  endfunction

  task automatic test_back_to_back();
    logic [W:0] q[$];
    logic [W:0] exp;
    int         cyc;
    int         n_acc;
    int         n_done;
    int         last_acc;
    logic       fire_in;
    logic       fire_out;
    cyc = 0; n_acc = 0; n_done = 0; last_acc = -100;
    bus.in_op    = 2'($urandom_range(0, 3));
    bus.in_data  = 4'($urandom_range(0, 15));
    bus.in_valid = 1'b1;
    while (n_done < 20 && cyc < 2000) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      fire_in  = bus.in_valid && bus.in_ready;
      fire_out = bus.out_valid && bus.out_ready;
      if (fire_out) begin
        exp = (q.size() > 0) ? q.pop_front() : 5'bxxxxx;
        checks++;
        if ({bus.out_ovf, bus.out_data} !== exp) begin
          errors++;
          $display("FAIL stream_result[%0d]: got %b/%b expected %b/%b", n_done,
                   bus.out_ovf, bus.out_data, exp[W], exp[W-1:0]);
        end
        n_done++;
      end
      if (fire_in) begin
        q.push_back(model(bus.in_op, bus.in_data));
        if (n_acc > 0) begin
          checks++;
          if (cyc - last_acc < 6) begin
            errors++;
            $display("FAIL stream_spacing[%0d]: got %0d expected >= 6", n_acc, cyc - last_acc);
          end
        end
        last_acc = cyc;
        n_acc++;
      end
      @(posedge clk); #1;
      cyc++;
      if (fire_in) begin
        if (n_acc < 20) begin
          bus.in_op   = 2'($urandom_range(0, 3));
          bus.in_data = 4'($urandom_range(0, 15));
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    checks++;
    if (n_done != 20) begin
      errors++; $display("FAIL stream_count: got %0d expected 20", n_done);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_twos();
    test_ops();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
